sample_gather4: RTL and testbench
=================================

// Module: sample_gather4
// PURPOSE
//   Upstream feeder for the four-input registered adder stage. Accepts a serial
//   stream of 16-bit samples over a valid/ready handshake, packs each group of
//   four consecutive samples into parallel lanes in1..in4, and presents the
//   group with m_valid until the consumer takes it.
//   With m_ready tied high, the adder result is valid one clock after m_valid&&m_ready.
// PARAMETERS
//   DATA_W   16   width of each sample and each output lane
//   CNT_W    8    width of the emitted-group counter grp_cnt
// PORTS
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   s_data   in   DATA_W   input sample
//   s_valid  in   1        s_data valid
//   s_ready  out  1        block can accept s_data this cycle
//   clr      in   1        synchronous discard of a partial group
//   in1      out  DATA_W   lane 0, the first sample of the group
//   in2      out  DATA_W   lane 1
//   in3      out  DATA_W   lane 2
//   in4      out  DATA_W   lane 3, the last sample of the group
//   m_valid  out  1        in1..in4 hold a complete group
//   m_ready  in   1        consumer takes the group this cycle
//   grp_cnt  out  CNT_W    number of groups handed off, wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async): state=FILL, idx=0, in1..in4=0, m_valid=0, grp_cnt=0.
//     s_ready=1 at the first clock after release.
//   Handshakes: s_acc = s_valid && s_ready; m_acc = m_valid && m_ready.
//   State FILL (m_valid=0, s_ready=1):
//     - on s_acc: lane[idx] <= s_data, idx <= idx+1.
//     - the s_acc with idx==3 sets idx <= 0, state <= FULL, m_valid <= 1 (next cycle).
//   State FULL (m_valid=1, s_ready=m_ready, combinational):
//     - lanes are frozen while m_ready=0; s_ready=0 (back-pressure).
//     - m_acc: grp_cnt <= grp_cnt+1 (wraps, 2^CNT_W-1 -> 0), state <= FILL,
//       m_valid <= 0.
//     - m_acc && s_acc in the same cycle: the new sample is written to lane 0,
//       idx <= 1, so one sample per clock is sustained with no bubble.
//   Latency: m_valid rises on the clock edge that accepts the 4th sample.
//     The minimum period is 4 cycles per group.
//   Lane outputs are registered. Lanes not yet rewritten in FILL keep stale data;
//     the consumer qualifies them only by m_valid.
//   clr (sync, active-high):
//     - in FILL: idx <= 0. Any s_acc in the same cycle is dropped; clr wins.
//     - in FULL: ignored. A complete group is never discarded.
//   Reset mid-group or mid-handoff: the partial or pending group is lost.
//     State, idx, lanes, m_valid and grp_cnt all return to their reset values.
//   s_valid=1 in FULL with m_ready=0: the sample is not accepted. The source must
//     hold s_data/s_valid stable until s_ready.
//   m_valid and lanes never change while m_valid=1 && m_ready=0.
//   No arithmetic on the data path; only idx (2-bit) and grp_cnt wrap silently.
// TESTING
//   1 Reset: rst_n=0 mid-group (2 samples in) -> all outputs 0 asynchronously.
//     After release, s_ready=1 and the next sample lands in in1.
//   2 Basic group: send 0x0001,0x0002,0x0003,0xFFFF with m_ready=1 ->
//     in1..in4=1,2,3,FFFF, m_valid high for exactly 1 cycle, grp_cnt=1.
//     The downstream adder out reads 0x10005 one cycle later.
//   3 Back-pressure: m_ready=0 for 5 cycles after a full group with s_valid=1 ->
//     s_ready=0, lanes and m_valid stable. The 5th sample is accepted into in1 on
//     the cycle m_ready rises.
//   4 Streaming: 12 samples back-to-back, s_valid=1, m_ready=1 -> 3 groups, no
//     stall, m_valid on cycles 4, 8 and 12, grp_cnt=3.
//   5 clr: 2 samples (0xAAAA,0xBBBB), then clr together with s_valid (0xCCCC),
//     then 4 samples 1..4 -> group emitted is 1,2,3,4. clr asserted in FULL has
//     no effect.
//   6 Wrap: CNT_W=2, emit 5 groups -> grp_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sample_gather4_if.sv
// Handshake bundle for sample_gather4: serial sample input plus the
// four-lane group output with its valid/ready pair.
interface sample_gather4_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic [DATA_W-1:0] in4;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, in1, in2, in3, in4, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, in1, in2, in3, in4, m_valid
  );
endinterface

// File: rtl/sample_gather4.sv
// Packs four consecutive stream samples into parallel lanes in1..in4 and
// holds the group with m_valid until the consumer takes it.
//
//   state | meaning
//   FILL  | collecting samples into lane[idx], s_ready=1
//   FULL  | complete group presented, s_ready follows m_ready
module sample_gather4 #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  sample_gather4_if.slave  bus,
  output logic [CNT_W-1:0] grp_cnt
);

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] lane_q [4];
  logic [DATA_W-1:0] lane_d [4];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_acc, m_acc;

  assign bus.m_valid = (state_q == FULL);
  assign bus.s_ready = (state_q == FILL) || bus.m_ready;
  assign bus.in1     = lane_q[0];
  assign bus.in2     = lane_q[1];
  assign bus.in3     = lane_q[2];
  assign bus.in4     = lane_q[3];
  assign grp_cnt     = cnt_q;

  assign s_acc = bus.s_valid && bus.s_ready;
  assign m_acc = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      for (int i = 0; i < 4; i++) lane_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < 4; i++) lane_q[i] <= lane_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) lane_d[i] = lane_q[i];

    unique case (state_q)
      FILL: begin
        // clr beats a same-cycle sample: the partial group restarts empty
        if (clr) begin
          idx_d = 2'd0;
        end else if (s_acc) begin
          lane_d[idx_q] = bus.s_data;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = FULL;
        end
      end
      FULL: begin
        // clr is ignored here so a complete group is never thrown away
        if (m_acc) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = FILL;
          idx_d   = 2'd0;
          if (s_acc) begin
            lane_d[0] = bus.s_data;
            idx_d     = 2'd1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_sample_gather4.sv
// Directed bench for sample_gather4: vector table plus hand sequences for
// async reset and grp_cnt wrap (second instance with CNT_W=2).
module tb_sample_gather4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [7:0] grp_cnt;
  logic [1:0] grp_cnt_w;
  logic [17:0] sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sample_gather4_if #(.DATA_W(16)) bus ();
  sample_gather4_if #(.DATA_W(16)) bus_w ();

  assign bus_w.s_data  = bus.s_data;
  assign bus_w.s_valid = bus.s_valid;
  assign bus_w.m_ready = bus.m_ready;

  sample_gather4 #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus.slave), .grp_cnt(grp_cnt)
  );

  sample_gather4 #(.DATA_W(16), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus_w.slave), .grp_cnt(grp_cnt_w)
  );

  // downstream four-input registered adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum <= '0;
    else if (bus.m_valid && bus.m_ready)
      sum <= 18'(bus.in1) + 18'(bus.in2) + 18'(bus.in3) + 18'(bus.in4);
  end

  typedef struct {
    logic        rst;
    logic        sv;
    logic [15:0] d;
    logic        mr;
    logic        cl;
    logic        sr;
    logic        mv;
    logic [15:0] l1, l2, l3, l4;
    logic [7:0]  cnt;
    logic [17:0] sm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic sv, input logic [15:0] d,
                     input logic mr, input logic cl, input logic sr, input logic mv,
                     input logic [15:0] l1, input logic [15:0] l2,
                     input logic [15:0] l3, input logic [15:0] l4,
                     input logic [7:0] cnt, input logic [17:0] sm);
    vec_t v;
    v.rst = r; v.sv = sv; v.d = d; v.mr = mr; v.cl = cl; v.sr = sr; v.mv = mv;
    v.l1 = l1; v.l2 = l2; v.l3 = l3; v.l4 = l4; v.cnt = cnt; v.sm = sm;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0; clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic sv, input logic [15:0] d, input logic mr, input logic cl);
    @(negedge clk);
    bus.s_valid = sv; bus.s_data = d; bus.m_ready = mr; clr = cl;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_w [5];

  initial begin
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    exp_w[0] = 2'd1; exp_w[1] = 2'd2; exp_w[2] = 2'd3; exp_w[3] = 2'd0; exp_w[4] = 2'd1;

    //  rst sv  d        mr cl  sr mv  l1       l2       l3       l4       cnt sum
    // basic group, adder result one cycle after handoff
    add(1, 1, 16'h0001, 1, 0,  1, 0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0002, 1, 0,  1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0003, 1, 0,  1, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0, 0);
    add(0, 1, 16'hFFFF, 1, 0,  1, 1, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 0, 0);
    add(0, 0, 16'h0000, 1, 0,  1, 0, 16'h0001, 16'h0002, 16'h0003, 16'hFFFF, 1, 18'h10005);
    // back-pressure
    add(1, 1, 16'h0005, 0, 0,  1, 0, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0006, 0, 0,  1, 0, 16'h0005, 16'h0006, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0007, 0, 0,  1, 0, 16'h0005, 16'h0006, 16'h0007, 16'h0000, 0, 0);
    add(0, 1, 16'h0008, 0, 0,  1, 1, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 0, 0);
    for (int i = 0; i < 5; i++)
      add(0, 1, 16'h0009, 0, 0, 0, 1, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 0, 0);
    add(0, 1, 16'h0009, 1, 0,  1, 0, 16'h0009, 16'h0006, 16'h0007, 16'h0008, 1, 18'h1A);
    // streaming 12 samples
    add(1, 1, 16'h0011, 1, 0,  1, 0, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0012, 1, 0,  1, 0, 16'h0011, 16'h0012, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0013, 1, 0,  1, 0, 16'h0011, 16'h0012, 16'h0013, 16'h0000, 0, 0);
    add(0, 1, 16'h0014, 1, 0,  1, 1, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 0, 0);
    add(0, 1, 16'h0015, 1, 0,  1, 0, 16'h0015, 16'h0012, 16'h0013, 16'h0014, 1, 18'h4A);
    add(0, 1, 16'h0016, 1, 0,  1, 0, 16'h0015, 16'h0016, 16'h0013, 16'h0014, 1, 18'h4A);
    add(0, 1, 16'h0017, 1, 0,  1, 0, 16'h0015, 16'h0016, 16'h0017, 16'h0014, 1, 18'h4A);
    add(0, 1, 16'h0018, 1, 0,  1, 1, 16'h0015, 16'h0016, 16'h0017, 16'h0018, 1, 18'h4A);
    add(0, 1, 16'h0019, 1, 0,  1, 0, 16'h0019, 16'h0016, 16'h0017, 16'h0018, 2, 18'h5A);
    add(0, 1, 16'h001A, 1, 0,  1, 0, 16'h0019, 16'h001A, 16'h0017, 16'h0018, 2, 18'h5A);
    add(0, 1, 16'h001B, 1, 0,  1, 0, 16'h0019, 16'h001A, 16'h001B, 16'h0018, 2, 18'h5A);
    add(0, 1, 16'h001C, 1, 0,  1, 1, 16'h0019, 16'h001A, 16'h001B, 16'h001C, 2, 18'h5A);
    add(0, 0, 16'h0000, 1, 0,  1, 0, 16'h0019, 16'h001A, 16'h001B, 16'h001C, 3, 18'h6A);
    // clr drops partial group and same-cycle sample; ignored in FULL
    add(1, 1, 16'hAAAA, 1, 0,  1, 0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'hBBBB, 1, 0,  1, 0, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'hCCCC, 1, 1,  1, 0, 16'hAAAA, 16'hBBBB, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0001, 1, 0,  1, 0, 16'h0001, 16'hBBBB, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0002, 1, 0,  1, 0, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 16'h0003, 1, 0,  1, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 0, 0);
    add(0, 1, 16'h0004, 0, 0,  1, 1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0);
    add(0, 0, 16'h0000, 0, 1,  0, 1, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 0, 0);
    add(0, 0, 16'h0000, 1, 1,  1, 0, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 1, 18'hA);
    add(0, 1, 16'h0005, 1, 0,  1, 0, 16'h0005, 16'h0002, 16'h0003, 16'h0004, 1, 18'hA);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      bus.s_valid = tbl[i].sv; bus.s_data = tbl[i].d;
      bus.m_ready = tbl[i].mr; clr = tbl[i].cl;
      #1;
      chk($sformatf("v%0d s_ready", i), 32'(bus.s_ready), 32'(tbl[i].sr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d m_valid", i), 32'(bus.m_valid), 32'(tbl[i].mv));
      chk($sformatf("v%0d in1", i), 32'(bus.in1), 32'(tbl[i].l1));
      chk($sformatf("v%0d in2", i), 32'(bus.in2), 32'(tbl[i].l2));
      chk($sformatf("v%0d in3", i), 32'(bus.in3), 32'(tbl[i].l3));
      chk($sformatf("v%0d in4", i), 32'(bus.in4), 32'(tbl[i].l4));
      chk($sformatf("v%0d grp_cnt", i), 32'(grp_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d adder", i), 32'(sum), 32'(tbl[i].sm));
    end

    // async reset mid-group
    do_reset();
    step(1, 16'h1111, 1, 0);
    step(1, 16'h2222, 1, 0);
    chk("pre_rst in2", 32'(bus.in2), 32'h2222);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst in1", 32'(bus.in1), 32'h0);
    chk("async_rst in2", 32'(bus.in2), 32'h0);
    chk("async_rst m_valid", 32'(bus.m_valid), 32'h0);
    chk("async_rst grp_cnt", 32'(grp_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 16'h1234; bus.m_ready = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst s_ready", 32'(bus.s_ready), 32'h1);
    chk("post_rst in1", 32'(bus.in1), 32'h1234);
    chk("post_rst in2", 32'(bus.in2), 32'h0);

    // grp_cnt wrap on the CNT_W=2 instance
    do_reset();
    for (int g = 0; g < 5; g++) begin
      for (int s = 0; s < 4; s++) step(1, 16'((g << 4) + s), 1, 0);
      chk($sformatf("wrap%0d m_valid", g), 32'(bus_w.m_valid), 32'h1);
      chk($sformatf("wrap%0d in4", g), 32'(bus_w.in4), 32'((g << 4) + 3));
      step(0, 16'h0000, 1, 0);
      chk($sformatf("wrap%0d grp_cnt_w", g), 32'(grp_cnt_w), 32'(exp_w[g]));
      chk($sformatf("wrap%0d grp_cnt", g), 32'(grp_cnt), 32'(g + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
